// File: rtl/bank_isu.sv
// rtl/bank_isu.sv - bank refill issue unit: line FIFO, two-beat SRAM write issue, done pulse
// Optional feature macro: ISU_PERF_CNT_EN (adds isu_perf_refill_cnt_o completed-line counter)
module bank_isu #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  biu_isu_rvalid_i,
  output logic                  biu_isu_rready_o,
  input  logic [DATA_WIDTH-1:0] biu_isu_rdata_i,
  input  logic [ID_WIDTH-1:0]   biu_isu_rid_i,
  output logic                  isu_sc_valid_o,
  input  logic                  isu_sc_ready_i,
  output logic [127:0]          isu_sc_data_o,
  output logic [ID_WIDTH:0]     isu_sc_set_way_offset_o,
  output logic                  isu_htu_done_valid_o,
  output logic [ID_WIDTH-1:0]   isu_htu_done_id_o
`ifdef ISU_PERF_CNT_EN
  ,
  output logic [31:0]           isu_perf_refill_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {BEAT_LO = 1'b0, BEAT_HI = 1'b1} beat_t;

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   id_mem   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  beat_t                 beat;
  logic                  done_valid;
  logic [ID_WIDTH-1:0]   done_id;

  logic push;
  logic fire;
  logic pop;

  // Readiness depends on occupancy only, so a full FIFO never accepts even when popping.
  assign biu_isu_rready_o = (count != CW'(FIFO_DEPTH));
  assign isu_sc_valid_o   = (count != '0);
  assign push             = biu_isu_rvalid_i & biu_isu_rready_o;
  assign fire             = isu_sc_valid_o & isu_sc_ready_i;
  assign pop              = fire & (beat == BEAT_HI);

  assign isu_sc_data_o           = (beat == BEAT_HI) ? data_mem[rd_ptr][DATA_WIDTH-1 -: 128]
                                                     : data_mem[rd_ptr][127:0];
  assign isu_sc_set_way_offset_o = {id_mem[rd_ptr], beat};
  assign isu_htu_done_valid_o    = done_valid;
  assign isu_htu_done_id_o       = done_id;

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr] <= biu_isu_rdata_i;
      id_mem[wr_ptr]   <= biu_isu_rid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat       <= BEAT_LO;
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fire) beat <= (beat == BEAT_LO) ? BEAT_HI : BEAT_LO;
      done_valid <= pop;
      if (pop) done_id <= id_mem[rd_ptr];
    end
  end

`ifdef ISU_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)    perf_cnt <= '0;
    else if (pop) perf_cnt <= perf_cnt + 32'd1;
  end

  assign isu_perf_refill_cnt_o = perf_cnt;
`endif

endmodule

// File: tb/tb_bank_isu.sv
// tb/tb_bank_isu.sv - directed self-checking bench for bank_isu
// Perf counter scenario compiled only with ISU_PERF_CNT_EN.
module tb_bank_isu;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [255:0] rdata = '0;
  logic [5:0]   rid = '0;
  logic         sc_valid;
  logic         sc_ready = 1'b0;
  logic [127:0] sc_data;
  logic [6:0]   swo;
  logic         done_valid;
  logic [5:0]   done_id;
`ifdef ISU_PERF_CNT_EN
  logic [31:0]  perf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bank_isu dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .biu_isu_rvalid_i        (rvalid),
    .biu_isu_rready_o        (rready),
    .biu_isu_rdata_i         (rdata),
    .biu_isu_rid_i           (rid),
    .isu_sc_valid_o          (sc_valid),
    .isu_sc_ready_i          (sc_ready),
    .isu_sc_data_o           (sc_data),
    .isu_sc_set_way_offset_o (swo),
    .isu_htu_done_valid_o    (done_valid),
    .isu_htu_done_id_o       (done_id)
`ifdef ISU_PERF_CNT_EN
    ,
    .isu_perf_refill_cnt_o   (perf)
`endif
  );

  function automatic logic [127:0] lo_of(input logic [5:0] id);
    return {16{{2'b01, id}}};
  endfunction

  function automatic logic [127:0] hi_of(input logic [5:0] id);
    return {16{{2'b10, id}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rvalid = 1'b0; sc_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rvalid = 1'b0; sc_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL reset_rready: got %b exp 1", rready); end
    n_cmp++; if (sc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", sc_valid); end
    n_cmp++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b exp 0", done_valid); end
    n_cmp++; if (done_id !== 6'h00) begin n_err++; $display("FAIL reset_done_id: got %h exp 00", done_id); end
`ifdef ISU_PERF_CNT_EN
    n_cmp++; if (perf !== 32'd0) begin n_err++; $display("FAIL reset_perf: got %h exp 0", perf); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single_line();
    logic [127:0] a_lo;
    logic [127:0] b_hi;
    a_lo = {32{4'hA}};
    b_hi = {32{4'hB}};
    sc_ready = 1'b1;
    rvalid = 1'b1; rid = 6'h2A; rdata = {b_hi, a_lo};
    tick();
    rvalid = 1'b0;
    n_cmp++; if (sc_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_lo: got %b exp 1", sc_valid); end
    n_cmp++; if (swo !== {6'h2A, 1'b0}) begin n_err++; $display("FAIL single_swo_lo: got %h exp %h", swo, {6'h2A, 1'b0}); end
    n_cmp++; if (sc_data !== a_lo) begin n_err++; $display("FAIL single_data_lo: got %h exp %h", sc_data, a_lo); end
    n_cmp++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL single_early_done: got %b exp 0", done_valid); end
    tick();
    n_cmp++; if (swo !== {6'h2A, 1'b1}) begin n_err++; $display("FAIL single_swo_hi: got %h exp %h", swo, {6'h2A, 1'b1}); end
    n_cmp++; if (sc_data !== b_hi) begin n_err++; $display("FAIL single_data_hi: got %h exp %h", sc_data, b_hi); end
    n_cmp++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL single_done_hi: got %b exp 0", done_valid); end
    tick();
    n_cmp++; if (done_valid !== 1'b1) begin n_err++; $display("FAIL single_done: got %b exp 1", done_valid); end
    n_cmp++; if (done_id !== 6'h2A) begin n_err++; $display("FAIL single_done_id: got %h exp 2a", done_id); end
    n_cmp++; if (sc_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_end: got %b exp 0", sc_valid); end
    tick();
    n_cmp++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL single_done_once: got %b exp 0", done_valid); end
  endtask

  task automatic test_backpressure();
    sc_ready = 1'b0;
    rvalid = 1'b1; rid = 6'h05; rdata = {hi_of(6'h05), lo_of(6'h05)};
    tick();
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL bp_rready_one: got %b exp 1", rready); end
    rid = 6'h06; rdata = {hi_of(6'h06), lo_of(6'h06)};
    tick();
    rid = 6'h07; rdata = {hi_of(6'h07), lo_of(6'h07)};
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL bp_rready_full[%0d]: got %b exp 0", i, rready); end
      n_cmp++; if (sc_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold[%0d]: got %b exp 1", i, sc_valid); end
      n_cmp++; if (swo !== {6'h05, 1'b0}) begin n_err++; $display("FAIL bp_swo_hold[%0d]: got %h exp %h", i, swo, {6'h05, 1'b0}); end
      n_cmp++; if (sc_data !== lo_of(6'h05)) begin n_err++; $display("FAIL bp_data_hold[%0d]: got %h exp %h", i, sc_data, lo_of(6'h05)); end
      tick();
    end
    sc_ready = 1'b1;
    tick();
    n_cmp++; if (swo !== {6'h05, 1'b1}) begin n_err++; $display("FAIL bp_swo_hi: got %h exp %h", swo, {6'h05, 1'b1}); end
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL bp_rready_hi: got %b exp 0", rready); end
    tick();
    n_cmp++; if (done_valid !== 1'b1 || done_id !== 6'h05) begin n_err++; $display("FAIL bp_done5: got %b/%h exp 1/05", done_valid, done_id); end
    n_cmp++; if (swo !== {6'h06, 1'b0}) begin n_err++; $display("FAIL bp_swo6: got %h exp %h", swo, {6'h06, 1'b0}); end
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL bp_rready_pop: got %b exp 1", rready); end
    tick();
    rvalid = 1'b0;
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL bp_third_acc: got %b exp 0", rready); end
    tick();
    n_cmp++; if (done_valid !== 1'b1 || done_id !== 6'h06) begin n_err++; $display("FAIL bp_done6: got %b/%h exp 1/06", done_valid, done_id); end
    n_cmp++; if (sc_data !== lo_of(6'h07)) begin n_err++; $display("FAIL bp_data7: got %h exp %h", sc_data, lo_of(6'h07)); end
    tick();
    tick();
    n_cmp++; if (done_valid !== 1'b1 || done_id !== 6'h07) begin n_err++; $display("FAIL bp_done7: got %b/%h exp 1/07", done_valid, done_id); end
    n_cmp++; if (sc_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b exp 0", sc_valid); end
  endtask

  task automatic test_full_pop();
    sc_ready = 1'b1;
    rvalid = 1'b1; rid = 6'h21; rdata = {hi_of(6'h21), lo_of(6'h21)};
    tick();
    rid = 6'h22; rdata = {hi_of(6'h22), lo_of(6'h22)};
    tick();
    rid = 6'h23; rdata = {hi_of(6'h23), lo_of(6'h23)};
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL fp_full: got %b exp 0", rready); end
    n_cmp++; if (swo !== {6'h21, 1'b1}) begin n_err++; $display("FAIL fp_swo_hi: got %h exp %h", swo, {6'h21, 1'b1}); end
    tick();
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL fp_rready_after_pop: got %b exp 1", rready); end
    n_cmp++; if (done_valid !== 1'b1 || done_id !== 6'h21) begin n_err++; $display("FAIL fp_done21: got %b/%h exp 1/21", done_valid, done_id); end
    n_cmp++; if (swo !== {6'h22, 1'b0}) begin n_err++; $display("FAIL fp_swo22: got %h exp %h", swo, {6'h22, 1'b0}); end
    tick();
    rvalid = 1'b0;
    n_cmp++; if (swo !== {6'h22, 1'b1}) begin n_err++; $display("FAIL fp_swo22hi: got %h exp %h", swo, {6'h22, 1'b1}); end
    tick();
    n_cmp++; if (done_valid !== 1'b1 || done_id !== 6'h22) begin n_err++; $display("FAIL fp_done22: got %b/%h exp 1/22", done_valid, done_id); end
    n_cmp++; if (swo !== {6'h23, 1'b0}) begin n_err++; $display("FAIL fp_next_line: got %h exp %h", swo, {6'h23, 1'b0}); end
    tick();
    tick();
    n_cmp++; if (done_valid !== 1'b1 || done_id !== 6'h23) begin n_err++; $display("FAIL fp_done23: got %b/%h exp 1/23", done_valid, done_id); end
  endtask

  task automatic test_back_to_back();
    logic       exp_valid [8];
    logic [6:0] exp_swo   [8];
    logic       exp_done  [8];
    logic [5:0] exp_did   [8];
    logic [127:0] exp_data;
    exp_valid = '{1, 1, 1, 1, 1, 1, 0, 0};
    exp_swo   = '{7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h00, 7'h00};
    exp_done  = '{0, 0, 1, 0, 1, 0, 1, 0};
    exp_did   = '{6'h00, 6'h00, 6'h01, 6'h01, 6'h02, 6'h02, 6'h03, 6'h03};
    sc_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      rvalid = (t % 2 == 0) && (t < 6);
      rid = 6'(t / 2 + 1);
      rdata = {hi_of(rid), lo_of(rid)};
      n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL b2b_rready[%0d]: got %b exp 1", t, rready); end
      tick();
      n_cmp++; if (sc_valid !== exp_valid[t]) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b exp %b", t, sc_valid, exp_valid[t]); end
      if (exp_valid[t]) begin
        exp_data = exp_swo[t][0] ? hi_of(exp_swo[t][6:1]) : lo_of(exp_swo[t][6:1]);
        n_cmp++; if (swo !== exp_swo[t]) begin n_err++; $display("FAIL b2b_swo[%0d]: got %h exp %h", t, swo, exp_swo[t]); end
        n_cmp++; if (sc_data !== exp_data) begin n_err++; $display("FAIL b2b_data[%0d]: got %h exp %h", t, sc_data, exp_data); end
      end
      n_cmp++; if (done_valid !== exp_done[t]) begin n_err++; $display("FAIL b2b_done[%0d]: got %b exp %b", t, done_valid, exp_done[t]); end
      if (exp_done[t]) begin
        n_cmp++; if (done_id !== exp_did[t]) begin n_err++; $display("FAIL b2b_done_id[%0d]: got %h exp %h", t, done_id, exp_did[t]); end
      end
    end
    rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    sc_ready = 1'b1;
    rvalid = 1'b1; rid = 6'h10; rdata = {hi_of(6'h10), lo_of(6'h10)};
    tick();
    rvalid = 1'b0;
    tick();
    n_cmp++; if (swo !== {6'h10, 1'b1}) begin n_err++; $display("FAIL rm_swo_hi: got %h exp %h", swo, {6'h10, 1'b1}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (sc_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b exp 0", sc_valid); end
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL rm_rready: got %b exp 1", rready); end
    n_cmp++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL rm_done_rst: got %b exp 0", done_valid); end
    tick();
    n_cmp++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_done: got %b exp 0", done_valid); end
    rvalid = 1'b1; rid = 6'h11; rdata = {hi_of(6'h11), lo_of(6'h11)};
    tick();
    rvalid = 1'b0;
    n_cmp++; if (swo !== {6'h11, 1'b0}) begin n_err++; $display("FAIL rm_new_lo: got %h exp %h", swo, {6'h11, 1'b0}); end
    n_cmp++; if (sc_data !== lo_of(6'h11)) begin n_err++; $display("FAIL rm_new_data: got %h exp %h", sc_data, lo_of(6'h11)); end
    tick();
    tick();
    n_cmp++; if (done_valid !== 1'b1 || done_id !== 6'h11) begin n_err++; $display("FAIL rm_done11: got %b/%h exp 1/11", done_valid, done_id); end
  endtask

`ifdef ISU_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    sc_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      rvalid = (t % 2 == 0);
      rid = 6'(t + 1);
      rdata = {hi_of(rid), lo_of(rid)};
      tick();
    end
    rvalid = 1'b0;
    tick();
    tick();
    n_cmp++; if (perf !== 32'd3) begin n_err++; $display("FAIL perf_three: got %h exp 3", perf); end
    force dut.perf_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.perf_cnt;
    rvalid = 1'b1; rid = 6'h3F; rdata = {hi_of(6'h3F), lo_of(6'h3F)};
    tick();
    rvalid = 1'b0;
    tick();
    n_cmp++; if (perf !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL perf_preload: got %h exp ffffffff", perf); end
    tick();
    n_cmp++; if (perf !== 32'd0) begin n_err++; $display("FAIL perf_wrap: got %h exp 0", perf); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_line();
    test_backpressure();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
`ifdef ISU_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bank_isu.md
# bank_isu

Bank refill issue unit: the stage directly downstream of the bank bus interface unit. It accepts 256-bit refill lines tagged with a set/way ID from the BIU read-return channel, buffers them in a small FIFO, and issues each line to the bank cache SRAM as two 128-bit write beats. It signals line completion back to the hit/tag unit.

## Interface

Parameters:
- DATA_WIDTH, 256, refill line width; fixed at 256 (two 128-bit SRAM beats).
- ID_WIDTH, 6, set/way tag width.
- FIFO_DEPTH, 2, line buffer entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- biu_isu_rvalid_i  in  1  refill line valid.
- biu_isu_rready_o  out  1  ISU can accept a line.
- biu_isu_rdata_i  in  DATA_WIDTH  refill line data.
- biu_isu_rid_i  in  ID_WIDTH  set/way of the line.
- isu_sc_valid_o  out  1  SRAM write beat valid.
- isu_sc_ready_i  in  1  SRAM accepts the beat.
- isu_sc_data_o  out  128  beat data.
- isu_sc_set_way_offset_o  out  ID_WIDTH+1  {set_way, offset}; offset 0 = low half, 1 = high half.
- isu_htu_done_valid_o  out  1  one-cycle pulse: line fully written.
- isu_htu_done_id_o  out  ID_WIDTH  set/way of the completed line.
- isu_perf_refill_cnt_o  out  32  completed-line count (only with ISU_PERF_CNT_EN).

## Operation

- FIFO of FIFO_DEPTH entries {id, data}. Uses write pointer, read pointer, and an occupancy count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- biu_isu_rready_o = (count != FIFO_DEPTH). Push on rvalid & rready.
- A line is never accepted while full, even if a pop occurs in the same cycle (no pass-through).
- Beat state: 1-bit register `beat` with two states.
  - BEAT_LO (0): head entry present → isu_sc_valid_o=1, data = head.data[127:0], offset=0. On handshake → BEAT_HI.
  - BEAT_HI (1): data = head.data[255:128], offset=1. On handshake → BEAT_LO, pop head, schedule done.
- isu_sc_valid_o = (count != 0). isu_sc_set_way_offset_o = {head.id, beat}.
- When valid=0, data and set_way_offset are don't-care; the bench must not check them.
- Valid/data are held stable until the handshake. `beat` advances only on isu_sc_valid_o & isu_sc_ready_i.
- Done: registered. isu_htu_done_valid_o=1 and isu_htu_done_id_o=head.id in the cycle after the BEAT_HI handshake, for exactly one cycle.
- Simultaneous push and pop (not full): count unchanged; both pointers advance.
- Reset mid-operation: FIFO emptied, partially written line discarded (no done pulse), beat=BEAT_LO.

## Timing

- Reset values: biu_isu_rready_o=1, isu_sc_valid_o=0, isu_htu_done_valid_o=0, isu_htu_done_id_o=0, isu_perf_refill_cnt_o=0. isu_sc_data_o and isu_sc_set_way_offset_o are don't-care.
- Latency: line pushed in cycle N → first beat valid in cycle N+1 (empty FIFO) → earliest high beat N+2 → done pulse N+3.
- Sustained throughput: one line per 2 cycles with isu_sc_ready_i held high. FIFO_DEPTH=2 never back-pressures a BIU that delivers at most one line per 2 cycles.
- All outputs derive from registered state only. There is no combinational path from any input to any output.

## Configuration

- ISU_PERF_CNT_EN defined: port isu_perf_refill_cnt_o exists. It is a 32-bit register, reset to 0, that increments by 1 in the same cycle the done pulse is scheduled (BEAT_HI handshake) and wraps 0xFFFF_FFFF→0.
- ISU_PERF_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan

- Single line: push id=0x2A, data={128'hB…B, 128'hA…A}, sc_ready=1 → cycle+1 beat {0x2A,0} data A…A; cycle+2 {0x2A,1} data B…B; cycle+3 done pulse id=0x2A.
- Back-pressure: sc_ready=0 for 5 cycles on the low beat → valid, data, and offset held constant; rready=0 after a second push (FIFO_DEPTH=2 full); a third rvalid is not accepted until the first line is popped.
- Back-to-back lines: ids 0x01, 0x02, 0x03 pushed every 2 cycles, sc_ready=1 → six beats in order with offsets 0,1,0,1,0,1; done pulses for ids 1, 2, 3 two cycles apart; rready never drops.
- Full + pop same cycle: FIFO full, BEAT_HI handshake while rvalid=1 → line not accepted that cycle; accepted the next cycle (rready=1).
- Reset mid-line: rst_i=1 right after the low-beat handshake of id=0x10 → no done pulse; valid=0 and rready=1 the next cycle; a new line id=0x11 then starts at offset 0.
- ISU_PERF_CNT_EN: after 3 completed lines, isu_perf_refill_cnt_o=3; preload 0xFFFF_FFFF through hierarchical force, complete one line → 0.
